uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   Front end and output buffer for a UART receiver. The controller:
//     * synchronises the asynchronous rx_in pin through two flops
//     * validates the start bit and times a center_tick strobe at every bit
//       centre for an external shift-register receiver
//     * detects a line break (line held low for 10 bit times after a frame)
//     * buffers each received byte for a ready/valid consumer and tracks
//       overrun and framing-error statistics
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   rx_in               raw UART pin, idle high
//   rx_sync_out         synchronised line (to the receiver)
//   center_tick         one-cycle strobe at each bit centre (to the receiver)
//   rx_data_in          byte from the receiver
//   valid_in            receiver byte-valid level; its rising edge captures
//   frame_error_in      receiver stop-bit error, qualified by valid_in
//   m_data, m_valid     buffered byte to the consumer
//   m_ready             consumer accepts when m_valid && m_ready
//   overrun             sticky flag: a good byte was dropped
//   overrun_clr         clears overrun (a simultaneous new overrun wins)
//   frame_err_cnt       saturating framing-error count
//   line_break          one-cycle strobe when a break is detected
//   busy                high while the bit-timing FSM is not idle
module uart_rx_ctrl #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic       rx_sync_out,
  output logic       center_tick,
  input  logic [7:0] rx_data_in,
  input  logic       valid_in,
  input  logic       frame_error_in,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       overrun,
  input  logic       overrun_clr,
  output logic [7:0] frame_err_cnt,
  output logic       line_break,
  output logic       busy
);

  localparam int TICKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT      = TICKS_PER_BIT / 2;

  localparam logic [15:0] TPB_C   = 16'(TICKS_PER_BIT);
  localparam logic [15:0] HALF_C  = 16'(HALF_BIT);
  localparam logic [15:0] BREAK_C = 16'(10 * TICKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START_CHK, RUN, HOLDOFF} state_t;

  logic        sync1_q, sync2_q;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  nticks_q, nticks_d;
  logic        tick_q, tick_d;
  logic        brk_q, brk_d;
  logic        brk_done_q, brk_done_d;
  logic        busy_q, busy_d;
  logic        valid_prev_q;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  fec_q, fec_d;
  logic        capture;

  // Bit-timing FSM next state. Outputs (tick, break, busy) are computed
  // here and registered so they line up with the state they belong to.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nticks_d   = nticks_q;
    tick_d     = 1'b0;
    brk_d      = 1'b0;
    brk_done_d = brk_done_q;
    case (state_q)
      IDLE: begin
        if (!sync2_q) begin
          state_d  = START_CHK;
          cnt_d    = 16'd1;
          nticks_d = 4'd0;
        end
      end
      START_CHK: begin
        if (sync2_q) begin
          // Start bit did not last half a bit: treat as a glitch.
          state_d = IDLE;
          cnt_d   = 16'd0;
        end else if (cnt_q == HALF_C) begin
          tick_d   = 1'b1;
          nticks_d = 4'd1;
          cnt_d    = 16'd1;
          state_d  = RUN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RUN: begin
        if (cnt_q == TPB_C) begin
          tick_d   = 1'b1;
          cnt_d    = 16'd1;
          nticks_d = nticks_q + 4'd1;
          // Tick number 10 is the stop-bit centre; wait for idle line.
          if (nticks_q == 4'd9) begin
            state_d    = HOLDOFF;
            brk_done_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      HOLDOFF: begin
        if (sync2_q) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end else if (!brk_done_q) begin
          // Counter freezes once the break has been reported so only one
          // strobe fires per low period.
          if (cnt_q == BREAK_C) begin
            brk_d      = 1'b1;
            brk_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Output buffer. valid_in is a level, so only its rising edge captures.
  always_comb begin
    capture   = valid_in && !valid_prev_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    overrun_d = overrun_q;
    fec_d     = fec_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (capture) begin
      if (frame_error_in) begin
        if (fec_q != 8'hFF) fec_d = fec_q + 8'd1;
      end else if (!m_valid_q || m_ready) begin
        m_data_d  = rx_data_in;
        m_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      nticks_q     <= 4'd0;
      tick_q       <= 1'b0;
      brk_q        <= 1'b0;
      brk_done_q   <= 1'b0;
      busy_q       <= 1'b0;
      valid_prev_q <= 1'b1;
      m_data_q     <= 8'h00;
      m_valid_q    <= 1'b0;
      overrun_q    <= 1'b0;
      fec_q        <= 8'h00;
    end else begin
      sync1_q      <= rx_in;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nticks_q     <= nticks_d;
      tick_q       <= tick_d;
      brk_q        <= brk_d;
      brk_done_q   <= brk_done_d;
      busy_q       <= busy_d;
      valid_prev_q <= valid_in;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      overrun_q    <= overrun_d;
      fec_q        <= fec_d;
    end
  end

  assign rx_sync_out   = sync2_q;
  assign center_tick   = tick_q;
  assign line_break    = brk_q;
  assign busy          = busy_q;
  assign m_data        = m_data_q;
  assign m_valid       = m_valid_q;
  assign overrun       = overrun_q;
  assign frame_err_cnt = fec_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a small behavioural receiver that
// shifts bits on center_tick and presents a byte-valid level after the stop bit.
module tb_uart_rx_ctrl;

  localparam int TPB  = 868;
  localparam int HALF = 434;

  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic       rx_in = 1'b1;
  logic       rx_sync_out, center_tick;
  logic [7:0] rx_data_in;
  logic       valid_in, frame_error_in;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       overrun;
  logic       overrun_clr = 1'b0;
  logic [7:0] frame_err_cnt;
  logic       line_break, busy;

  // Receiver model / direct stimulus selection
  logic       dir_mode = 1'b0;
  logic       dir_valid = 1'b0, dir_fe = 1'b0;
  logic [7:0] dir_data = 8'h00;
  logic       rcv_valid = 1'b0, rcv_fe = 1'b0;
  logic [7:0] rcv_data = 8'h00, rcv_shift = 8'h00;
  int         rtick = 0;

  assign valid_in       = dir_mode ? dir_valid : rcv_valid;
  assign rx_data_in     = dir_mode ? dir_data  : rcv_data;
  assign frame_error_in = dir_mode ? dir_fe    : rcv_fe;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   tick_q[$];
  int   brk_cnt = 0;
  logic consec = 1'b0;
  logic prev_tick = 1'b0;

  uart_rx_ctrl dut (
    .clk(clk), .reset(srst), .rx_in(rx_in), .rx_sync_out(rx_sync_out),
    .center_tick(center_tick), .rx_data_in(rx_data_in), .valid_in(valid_in),
    .frame_error_in(frame_error_in), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .overrun(overrun), .overrun_clr(overrun_clr),
    .frame_err_cnt(frame_err_cnt), .line_break(line_break), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Tick/break monitor
  always @(negedge clk) begin
    if (center_tick) tick_q.push_back(cyc);
    if (center_tick && prev_tick) consec <= 1'b1;
    prev_tick <= center_tick;
    if (line_break) brk_cnt <= brk_cnt + 1;
  end

  // Behavioural receiver: start, 8 data LSB first, stop
  always @(negedge clk) begin
    if (srst) begin
      rtick     <= 0;
      rcv_valid <= 1'b0;
    end else if (center_tick) begin
      if (rtick == 0) rcv_valid <= 1'b0;
      else if (rtick <= 8) rcv_shift[rtick-1] <= rx_sync_out;
      else begin
        rcv_data  <= rcv_shift;
        rcv_fe    <= ~rx_sync_out;
        rcv_valid <= 1'b1;
      end
      rtick <= (rtick == 9) ? 0 : rtick + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_in = 1'b0;
    step(TPB);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      step(TPB);
    end
    rx_in = stop;
    step(TPB);
  endtask

  task automatic check_reset_state(input string pfx);
    check_eq({pfx, "_rx_sync"},  rx_sync_out, 1);
    check_eq({pfx, "_tick"},     center_tick, 0);
    check_eq({pfx, "_m_data"},   m_data, 0);
    check_eq({pfx, "_m_valid"},  m_valid, 0);
    check_eq({pfx, "_overrun"},  overrun, 0);
    check_eq({pfx, "_fec"},      frame_err_cnt, 0);
    check_eq({pfx, "_brk"},      line_break, 0);
    check_eq({pfx, "_busy"},     busy, 0);
  endtask

  initial begin
    int t0;
    int n;
    int guard;

    step(3);
    srst = 1'b0;
    check_reset_state("rst0");
    step(20);

    // Single frame: tick timing, busy, captured byte
    tick_q.delete();
    t0 = cyc;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        step(4000);
        check_eq("t1_busy_mid", busy, 1);
      end
    join
    step(20);
    check_eq("t1_tick_count", tick_q.size(), 10);
    if (tick_q.size() >= 10) begin
      check_eq("t1_first_tick", tick_q[0] - t0, 2 + HALF + 1);
      for (int k = 1; k < 10; k++)
        check_eq($sformatf("t1_spacing_%0d", k), tick_q[k] - tick_q[k-1], TPB);
    end
    check_eq("t1_busy_end", busy, 0);
    check_eq("t1_m_valid", m_valid, 1);
    check_eq("t1_m_data", m_data, 8'hA5);
    m_ready = 1'b1;
    step(1);
    m_ready = 1'b0;
    check_eq("t1_drain", m_valid, 0);

    // Start-bit glitch
    tick_q.delete();
    rx_in = 1'b0;
    step(200);
    rx_in = 1'b1;
    step(1000);
    check_eq("t2_ticks", tick_q.size(), 0);
    check_eq("t2_busy", busy, 0);
    check_eq("t2_fec", frame_err_cnt, 0);

    // Overrun
    send_byte(8'h55, 1'b1);
    step(50);
    send_byte(8'hA3, 1'b1);
    step(50);
    check_eq("t3_m_data", m_data, 8'h55);
    check_eq("t3_m_valid", m_valid, 1);
    check_eq("t3_overrun", overrun, 1);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    check_eq("t3_overrun_clr", overrun, 0);
    m_ready = 1'b1;
    step(1);
    m_ready = 1'b0;
    check_eq("t3_drain", m_valid, 0);

    // Framing error then break
    step(50);
    tick_q.delete();
    brk_cnt = 0;
    send_byte(8'hC1, 1'b0);
    step(TPB * 11);
    check_eq("t4_fec", frame_err_cnt, 1);
    check_eq("t4_m_valid", m_valid, 0);
    check_eq("t4_break_cnt", brk_cnt, 1);
    check_eq("t4_ticks_low", tick_q.size(), 10);
    check_eq("t4_busy_low", busy, 1);
    rx_in = 1'b1;
    step(20);
    check_eq("t4_busy_idle", busy, 0);
    check_eq("t4_ticks_after", tick_q.size(), 10);

    // Direct capture cases
    dir_mode = 1'b1;
    step(2);
    dir_data = 8'h11; dir_fe = 1'b0; dir_valid = 1'b1;
    step(1);
    dir_valid = 1'b0;
    step(1);
    check_eq("t5_first_data", m_data, 8'h11);
    dir_data = 8'h3C; dir_valid = 1'b1; m_ready = 1'b1;
    step(1);
    dir_valid = 1'b0; m_ready = 1'b0;
    step(1);
    check_eq("t5_pass_data", m_data, 8'h3C);
    check_eq("t5_pass_valid", m_valid, 1);
    check_eq("t5_pass_overrun", overrun, 0);
    dir_data = 8'h77; dir_valid = 1'b1; overrun_clr = 1'b1;
    step(1);
    dir_valid = 1'b0; overrun_clr = 1'b0;
    step(1);
    check_eq("t5_set_wins", overrun, 1);
    check_eq("t5_held_data", m_data, 8'h3C);
    dir_fe = 1'b1; dir_valid = 1'b1;
    step(5);
    dir_valid = 1'b0;
    step(1);
    check_eq("t5_level_once", frame_err_cnt, 2);
    repeat (300) begin
      dir_valid = 1'b1;
      step(1);
      dir_valid = 1'b0;
      step(1);
    end
    check_eq("t5_fec_sat", frame_err_cnt, 8'hFF);

    // Reset mid-frame
    srst = 1'b1; dir_mode = 1'b0; dir_fe = 1'b0;
    step(1);
    srst = 1'b0;
    step(10);
    tick_q.delete();
    rx_in = 1'b0;
    guard = 0;
    while (tick_q.size() < 3 && guard < 5000) begin
      step(1);
      guard++;
    end
    check_eq("t6_reached_tick3", (guard < 5000), 1);
    srst = 1'b1;
    rx_in = 1'b1;
    step(1);
    srst = 1'b0;
    check_reset_state("t6");
    n = tick_q.size();
    step(2000);
    check_eq("t6_no_ticks", tick_q.size() - n, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("no_consec_ticks", consec, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
